// File: rtl/count_seg_display_pkg.sv
// Shared definitions for the counter display: segment table, stall FSM states,
// transition classes and the transition classifier.
package count_disp_pkg;

  typedef enum logic {
    ST_TRACK   = 1'b0,
    ST_STALLED = 1'b1
  } stall_state_e;

  localparam logic [2:0] CLS_HOLD    = 3'd0;
  localparam logic [2:0] CLS_STEP    = 3'd1;
  localparam logic [2:0] CLS_WRAP    = 3'd2;
  localparam logic [2:0] CLS_CLEAR   = 3'd3;
  localparam logic [2:0] CLS_ILLEGAL = 3'd4;

  // Segment bits are {g,f,e,d,c,b,a}, active-high, indexed by hex digit.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // A return to zero from 15 counts as a wrap; from anywhere else it is an upstream reset.
  function automatic logic [2:0] classify(input logic [3:0] old_v, input logic [3:0] new_v);
    logic [3:0] succ;
    succ = old_v + 4'd1;
    if (new_v == old_v)
      return CLS_HOLD;
    else if (new_v == succ)
      return (old_v == 4'hF) ? CLS_WRAP : CLS_STEP;
    else if (new_v == 4'h0)
      return CLS_CLEAR;
    else
      return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/count_seg_display_if.sv
// Bundle between the upstream counter/board and the display block.
interface count_seg_display_if;
  logic       ena;
  logic [3:0] count;
  logic       freeze;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] wraps;
  logic       stalled;
  logic       seq_err;

  modport master (
    output ena, count, freeze,
    input  seg, dp, wraps, stalled, seq_err
  );

  modport slave (
    input  ena, count, freeze,
    output seg, dp, wraps, stalled, seq_err
  );
endinterface

// File: rtl/count_seg_display_hex_to_seg7.sv
// Combinational hex digit to 7-segment decoder.
module hex_to_seg7
  import count_disp_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_LUT[i_hex];
endmodule

// File: rtl/count_seg_display.sv
// Samples the 4-bit upstream counter, drives the hex display and decimal point,
// and tracks wraps, stalls and illegal jumps.
module count_seg_display
  import count_disp_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  count_seg_display_if.slave  bus
);
  localparam logic [7:0] STALL_LAST = 8'(STALL_CYCLES - 1);

  logic [3:0]   r_count_q;
  logic [6:0]   r_seg;
  logic         r_dp;
  logic [7:0]   r_wraps;
  logic         r_seq_err;
  logic [7:0]   r_stall_cnt;
  stall_state_e r_state;

  logic [2:0]   w_cls;
  logic         w_hold;
  logic [6:0]   w_seg_dec;
  stall_state_e w_state_next;
  logic [7:0]   w_stall_cnt_next;

  hex_to_seg7 u_dec (
    .i_hex (bus.count),
    .o_seg (w_seg_dec)
  );

  assign w_cls  = classify(r_count_q, bus.count);
  assign w_hold = (w_cls == CLS_HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count_q <= 4'h0;
      r_seg     <= 7'h3F;
      r_dp      <= 1'b0;
      r_wraps   <= 8'h00;
      r_seq_err <= 1'b0;
    end else if (bus.ena) begin
      r_count_q <= bus.count;
      if (!bus.freeze)
        r_seg <= w_seg_dec;
      if (w_cls == CLS_WRAP) begin
        r_wraps <= r_wraps + 8'd1;
        r_dp    <= ~r_dp;
      end
      if (w_cls == CLS_ILLEGAL)
        r_seq_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_TRACK;
      r_stall_cnt <= 8'h00;
    end else if (bus.ena) begin
      r_state     <= w_state_next;
      r_stall_cnt <= w_stall_cnt_next;
    end
  end

  // The count saturates at STALL_CYCLES while stalled; any movement restarts tracking.
  always_comb begin
    w_state_next     = r_state;
    w_stall_cnt_next = r_stall_cnt;
    case (r_state)
      ST_TRACK: begin
        if (w_hold) begin
          w_stall_cnt_next = r_stall_cnt + 8'd1;
          if (r_stall_cnt == STALL_LAST)
            w_state_next = ST_STALLED;
        end else begin
          w_stall_cnt_next = 8'h00;
        end
      end
      ST_STALLED: begin
        if (!w_hold) begin
          w_state_next     = ST_TRACK;
          w_stall_cnt_next = 8'h00;
        end
      end
      default: begin
        w_state_next     = ST_TRACK;
        w_stall_cnt_next = 8'h00;
      end
    endcase
  end

  assign bus.seg     = r_seg;
  assign bus.dp      = r_dp;
  assign bus.wraps   = r_wraps;
  assign bus.seq_err = r_seq_err;
  assign bus.stalled = (r_state == ST_STALLED);

endmodule

// File: tb/tb_count_seg_display.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares each edge.
module tb_count_seg_display;
  localparam int STALL = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  count_seg_display_if bus();

  count_seg_display #(.STALL_CYCLES(STALL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] cnt;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] wraps;
    logic       stalled;
    logic       seq_err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int txn = 0;

  logic [6:0] seg_tbl [16];
  int   m_prev, m_run, m_wraps, cur;
  logic m_dp, m_err;
  logic [6:0] m_seg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_run = 0; m_wraps = 0;
    m_dp = 1'b0; m_err = 1'b0; m_seg = seg_tbl[0];
  endtask

  function automatic exp_t snapshot(input int c);
    exp_t e;
    e.cnt     = 4'(c);
    e.seg     = m_seg;
    e.dp      = m_dp;
    e.wraps   = 8'(m_wraps);
    e.stalled = (m_run >= STALL);
    e.seq_err = m_err;
    return e;
  endfunction

  // Reference rules: difference of +1 mod 16 is a step (wrap if from 15),
  // unchanged is a hold, drop to zero is a legal clear, anything else is an error.
  task automatic drive(input logic e, input int c, input logic f);
    int d;
    @(negedge clk);
    bus.ena = e; bus.count = 4'(c); bus.freeze = f;
    cur = c;
    if (e) begin
      d = (c - m_prev + 16) % 16;
      if (c == m_prev) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_run = 0;
        if (d == 1) begin
          if (m_prev == 15) begin
            m_wraps = (m_wraps + 1) % 256;
            m_dp = ~m_dp;
          end
        end else if (c != 0) begin
          m_err = 1'b1;
        end
      end
      if (!f) m_seg = seg_tbl[c];
      m_prev = c;
    end
    exp_q.push_back(snapshot(c));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_seg"},     32'(bus.seg),     32'h3F);
    chk({tag, "_dp"},      32'(bus.dp),      32'h0);
    chk({tag, "_wraps"},   32'(bus.wraps),   32'h0);
    chk({tag, "_stalled"}, 32'(bus.stalled), 32'h0);
    chk({tag, "_seq_err"}, 32'(bus.seq_err), 32'h0);
  endtask

  // Reset lands between edges; the release cycle runs with ena low so nothing is sampled.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_vals("async_rst");
    model_reset();
    $display("txn reset asserted t=%0t", $time);
    @(negedge clk);
    bus.ena = 1'b0;
    reset = 1'b1;
    cur = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        chk("seg",     32'(bus.seg),     32'(e.seg));
        chk("dp",      32'(bus.dp),      32'(e.dp));
        chk("wraps",   32'(bus.wraps),   32'(e.wraps));
        chk("stalled", 32'(bus.stalled), 32'(e.stalled));
        chk("seq_err", 32'(bus.seq_err), 32'(e.seq_err));
        $display("txn %0d count=%0d seg=%h dp=%0b wraps=%0d stalled=%0b seq_err=%0b",
                 txn, e.cnt, bus.seg, bus.dp, bus.wraps, bus.stalled, bus.seq_err);
      end
    end
  end

  initial begin : stimulus
    int r, nxt;
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    bus.ena = 1'b0; bus.count = 4'h0; bus.freeze = 1'b0;
    model_reset();
    cur = 0;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;

    // single ramp, then three more that each cross 15->0
    for (int c = 0; c < 16; c++) drive(1'b1, c, 1'b0);
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 16; c++) drive(1'b1, c, 1'b0);

    // stall on 5, release with 6
    for (int c = 0; c <= 5; c++) drive(1'b1, c, 1'b0);
    repeat (6) drive(1'b1, 5, 1'b0);
    drive(1'b1, 6, 1'b0);

    // legal clear, then an illegal jump that must stick
    drive(1'b1, 7, 1'b0);
    drive(1'b1, 0, 1'b0);
    drive(1'b1, 9, 1'b0);
    for (int c = 10; c < 14; c++) drive(1'b1, c, 1'b0);
    do_reset();

    // freeze held across a wrap, released afterwards
    for (int c = 0; c <= 3; c++) drive(1'b1, c, 1'b0);
    for (int c = 4; c < 18; c++) drive(1'b1, c % 16, 1'b1);
    drive(1'b1, 2, 1'b0);
    drive(1'b1, 3, 1'b0);

    // ena low cycles mixed into a ramp
    for (int c = 4; c < 10; c++) begin
      drive(1'b0, c, 1'b0);
      drive(1'b1, c, 1'b0);
    end
    do_reset();

    // enough wraps to roll the tally past 255
    for (int k = 0; k < 258; k++)
      for (int c = 0; c < 16; c++) drive(1'b1, c, 1'b0);

    // randomized traffic with occasional async resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 55)      nxt = (cur + 1) % 16;
        else if (r < 80) nxt = cur;
        else if (r < 88) nxt = 0;
        else             nxt = $urandom_range(0, 15);
        drive($urandom_range(0, 99) < 85, nxt, $urandom_range(0, 3) == 0);
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
